// File: rtl/lsu_pkg.sv
// Shared LSU types: opcode/funct3 constants, FSM state enum, request payload and access-size helpers.
package lsu_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   localparam logic [2:0] FUNCT3_LB  = 3'b000;
   localparam logic [2:0] FUNCT3_LH  = 3'b001;
   localparam logic [2:0] FUNCT3_LW  = 3'b010;
   localparam logic [2:0] FUNCT3_LBU = 3'b100;
   localparam logic [2:0] FUNCT3_LHU = 3'b101;
   localparam logic [2:0] FUNCT3_SB  = 3'b000;
   localparam logic [2:0] FUNCT3_SH  = 3'b001;
   localparam logic [2:0] FUNCT3_SW  = 3'b010;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} lsu_state_t;

   typedef struct packed {
      logic            is_store;
      logic [2:0]      funct3;
      logic [XLEN-1:0] addr;
      logic [XLEN-1:0] wdata;
   } lsu_req_t;

   // log2 of the access size in bytes; unlisted codes fall back to a word access
   function automatic logic [1:0] size_log2(input logic is_store, input logic [2:0] funct3);
      logic [1:0] sz;
      if (is_store) begin
         case (funct3)
            FUNCT3_SB: sz = 2'd0;
            FUNCT3_SH: sz = 2'd1;
            default:   sz = 2'd2;
         endcase
      end else begin
         case (funct3)
            FUNCT3_LB, FUNCT3_LBU: sz = 2'd0;
            FUNCT3_LH, FUNCT3_LHU: sz = 2'd1;
            default:               sz = 2'd2;
         endcase
      end
      return sz;
   endfunction

   function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] lo);
      return ((sz == 2'd1) && lo[0]) || ((sz == 2'd2) && (lo != 2'b00));
   endfunction

   // byte offset within the word with the low bits the access size cannot use cleared
   function automatic logic [1:0] align_off(input logic [1:0] sz, input logic [1:0] lo);
      logic [1:0] off;
      case (sz)
         2'd0:    off = lo;
         2'd1:    off = {lo[1], 1'b0};
         default: off = 2'b00;
      endcase
      return off;
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load lane extraction and sign/zero extension of a memory word.
module load_align
   import lsu_pkg::*;
(
   input  logic [2:0]      funct3,
   input  logic [1:0]      off,
   input  logic [XLEN-1:0] word,
   output logic [XLEN-1:0] data_c
);

   logic [7:0]  byte_c;
   logic [15:0] half_c;

   always_comb begin
      byte_c = 8'(word >> {off, 3'b000});
      half_c = off[1] ? word[31:16] : word[15:0];
      case (funct3)
         FUNCT3_LB:  data_c = {{24{byte_c[7]}}, byte_c};
         FUNCT3_LBU: data_c = {24'b0, byte_c};
         FUNCT3_LH:  data_c = {{16{half_c[15]}}, half_c};
         FUNCT3_LHU: data_c = {16'b0, half_c};
         default:    data_c = word;
      endcase
   end

endmodule

// File: rtl/lsu.sv
// Single-outstanding load/store unit with registered memory strobes.
// Optional LSU_MISALIGN_TRAP_EN: misaligned halfword/word accesses complete at once with resp_misaligned.
module lsu
   import lsu_pkg::*;
#(
   parameter int unsigned MEM_READ_LATENCY = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_is_store,
   input  logic [2:0]      req_funct3,
   input  logic [XLEN-1:0] req_addr,
   input  logic [XLEN-1:0] req_wdata,
   output logic            resp_valid,
   output logic [XLEN-1:0] resp_rdata,
   output logic            resp_misaligned,
   output logic [XLEN-1:0] mem_addr,
   output logic [XLEN-1:0] mem_wdata,
   output logic [3:0]      mem_wmask,
   output logic            mem_we,
   output logic            mem_re,
   input  logic [XLEN-1:0] mem_rdata
);

   localparam int unsigned CNT_W = 3;

   lsu_state_t      state_q, state_d;
   lsu_req_t        req_q, req_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic            req_ready_q, req_ready_d;
   logic            resp_valid_q, resp_valid_d;
   logic [XLEN-1:0] resp_rdata_q, resp_rdata_d;
   logic [XLEN-1:0] mem_addr_q, mem_addr_d;
   logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
   logic [3:0]      mem_wmask_q, mem_wmask_d;
   logic            mem_we_q, mem_we_d;
   logic            mem_re_q, mem_re_d;

   logic            accept_c, trap_c, rd_done_c;
   logic [1:0]      in_sz_c, lat_off_c;
   logic [3:0]      base_mask_c;
   logic [XLEN-1:0] load_data_c;

   assign accept_c  = req_valid && (state_q == IDLE);
   assign in_sz_c   = size_log2(req_is_store, req_funct3);
   assign lat_off_c = align_off(size_log2(req_q.is_store, req_q.funct3), req_q.addr[1:0]);
   assign rd_done_c = (cnt_q == CNT_W'(MEM_READ_LATENCY));

`ifdef LSU_MISALIGN_TRAP_EN
   logic resp_mis_q, resp_mis_d;
   assign trap_c          = accept_c && is_misaligned(in_sz_c, req_addr[1:0]);
   assign resp_misaligned = resp_mis_q;
`else
   assign trap_c          = 1'b0;
   assign resp_misaligned = 1'b0;
`endif

   load_align u_load_align (
      .funct3 (req_q.funct3),
      .off    (lat_off_c),
      .word   (mem_rdata),
      .data_c (load_data_c)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept_c) state_d = trap_c ? RESP : ISSUE;
         ISSUE:   state_d = req_q.is_store ? RESP : WAIT;
         WAIT:    if (rd_done_c) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      req_d        = req_q;
      cnt_d        = cnt_q;
      req_ready_d  = (state_d == IDLE);
      resp_valid_d = (state_d == RESP);
      resp_rdata_d = resp_rdata_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      mem_wmask_d  = 4'b0000;
      mem_we_d     = 1'b0;
      mem_re_d     = 1'b0;
      case (in_sz_c)
         2'd0:    base_mask_c = 4'b0001;
         2'd1:    base_mask_c = 4'b0011;
         default: base_mask_c = 4'b1111;
      endcase
`ifdef LSU_MISALIGN_TRAP_EN
      resp_mis_d = resp_mis_q;
`endif
      case (state_q)
         IDLE: begin
            if (accept_c) begin
               req_d.is_store = req_is_store;
               req_d.funct3   = req_funct3;
               req_d.addr     = req_addr;
               req_d.wdata    = req_wdata;
               cnt_d          = '0;
               resp_rdata_d   = '0;
`ifdef LSU_MISALIGN_TRAP_EN
               resp_mis_d     = trap_c;
`endif
               // strobes are registered here so they appear during the ISSUE cycle
               if (!trap_c) begin
                  mem_addr_d = {req_addr[31:2], 2'b00};
                  mem_we_d   = req_is_store;
                  mem_re_d   = !req_is_store;
                  if (req_is_store) begin
                     mem_wmask_d = 4'(base_mask_c << align_off(in_sz_c, req_addr[1:0]));
                     case (in_sz_c)
                        2'd0:    mem_wdata_d = {4{req_wdata[7:0]}};
                        2'd1:    mem_wdata_d = {2{req_wdata[15:0]}};
                        default: mem_wdata_d = req_wdata;
                     endcase
                  end
               end
            end
         end
         ISSUE: cnt_d = CNT_W'(1);
         WAIT: begin
            if (rd_done_c) resp_rdata_d = load_data_c;
            else           cnt_d = cnt_q + CNT_W'(1);
         end
         RESP:    cnt_d = '0;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         req_q        <= '0;
         cnt_q        <= '0;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         mem_wmask_q  <= '0;
         mem_we_q     <= 1'b0;
         mem_re_q     <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
         resp_mis_q   <= 1'b0;
`endif
      end else begin
         req_q        <= req_d;
         cnt_q        <= cnt_d;
         req_ready_q  <= req_ready_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         mem_wmask_q  <= mem_wmask_d;
         mem_we_q     <= mem_we_d;
         mem_re_q     <= mem_re_d;
`ifdef LSU_MISALIGN_TRAP_EN
         resp_mis_q   <= resp_mis_d;
`endif
      end
   end

   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign mem_wmask  = mem_wmask_q;
   assign mem_we     = mem_we_q;
   assign mem_re     = mem_re_q;

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 The module SHALL have parameter MEM_READ_LATENCY, default 1, meaning cycles from the mem_re cycle to the cycle mem_rdata is sampled (legal range 1..4).
REQ-002 The module SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-003 The module SHALL have port rst, input, 1, meaning reset, synchronous and active-high.
REQ-004 The module SHALL have port req_valid, input, 1, meaning an execute-stage memory request is presented.
REQ-005 The module SHALL have port req_ready, output, 1, meaning the request is accepted this cycle.
REQ-006 The module SHALL have port req_is_store, input, 1, meaning 1 for OP_STORE and 0 for OP_LOAD.
REQ-007 The module SHALL have port req_funct3, input, 3, meaning the width/sign code (FUNCT3_LB..LHU, FUNCT3_SB..SW).
REQ-008 The module SHALL have port req_addr, input, 32, meaning the byte address (rs1 + imm).
REQ-009 The module SHALL have port req_wdata, input, 32, meaning the store data (rs2).
REQ-010 The module SHALL have port resp_valid, output, 1, meaning a one-cycle completion pulse.
REQ-011 The module SHALL have port resp_rdata, output, 32, meaning the extended load result (0 for stores).
REQ-012 The module SHALL have port resp_misaligned, output, 1, meaning the completed request was misaligned.
REQ-013 The module SHALL have port mem_addr, output, 32, meaning the word-aligned memory address.
REQ-014 The module SHALL have port mem_wdata, output, 32, meaning the lane-replicated store data.
REQ-015 The module SHALL have port mem_wmask, output, 4, meaning the byte write enables.
REQ-016 The module SHALL have ports mem_we and mem_re, output, 1 each, meaning single-cycle write and read strobes.
REQ-017 The module SHALL have port mem_rdata, input, 32, meaning the memory read word.

Function
REQ-018 The FSM SHALL use states IDLE, ISSUE, WAIT and RESP.
REQ-019 req_ready SHALL be 1 only in IDLE; on req_valid && req_ready, addr, funct3, wdata and is_store SHALL be latched, and the FSM SHALL go to ISSUE.
REQ-020 In ISSUE, mem_addr SHALL be {addr[31:2],2'b00} for one cycle.
REQ-021 For a store in ISSUE, mem_we SHALL be 1, and the FSM SHALL then go to RESP.
REQ-022 For a load in ISSUE, mem_re SHALL be 1, and the FSM SHALL then go to WAIT.
REQ-023 Store masks SHALL be: SB 4'b0001<<addr[1:0]; SH 4'b0011<<{addr[1],1'b0}; SW 4'b1111.
REQ-024 Store data SHALL be: SB {4{wdata[7:0]}}; SH {2{wdata[15:0]}}; SW wdata.
REQ-025 In WAIT, a counter SHALL count MEM_READ_LATENCY cycles after the mem_re cycle, then sample mem_rdata and go to RESP.
REQ-026 Loads SHALL select the byte/halfword lane by addr[1:0]; LB/LH SHALL sign-extend, LBU/LHU SHALL zero-extend, and LW SHALL pass the word through.
REQ-027 In RESP, resp_valid SHALL be 1 for exactly one cycle with resp_rdata held stable, then the FSM SHALL return to IDLE.
REQ-028 Store latency SHALL be: accept T, mem_we T+1, resp_valid T+2.
REQ-029 Load latency SHALL be: accept T, mem_re T+1, sample T+1+L, resp_valid T+2+L.
REQ-030 Unlisted load funct3 (011, 110, 111) SHALL behave as LW, and store funct3 > 010 SHALL behave as SW.
REQ-031 Outside ISSUE, mem_we, mem_re and mem_wmask SHALL be 0, and mem_addr and mem_wdata SHALL hold.
REQ-032 req_valid while busy SHALL be ignored with no queueing.

Reset
REQ-033 rst SHALL force IDLE at the next edge from any state.
REQ-034 rst SHALL clear all outputs to 0 except req_ready=1.
REQ-035 rst SHALL clear the counter and latched request.
REQ-036 On reset mid-load, late mem_rdata SHALL be ignored, and no resp_valid SHALL be produced for the aborted request.
REQ-037 A store already strobed before reset SHALL not be retracted.

Configuration
REQ-038 With LSU_MISALIGN_TRAP_EN defined, halfword with addr[0]=1 or word with addr[1:0]!=0 SHALL skip ISSUE/WAIT, go to RESP with resp_misaligned=1 and resp_rdata=0, and produce no memory strobe (accept T, resp_valid T+1).
REQ-039 Without LSU_MISALIGN_TRAP_EN, offending low address bits SHALL be cleared before lane selection, and resp_misaligned SHALL be tied 0.

Structure
REQ-040 The lsu_state_t enum SHALL be added to the shared types package, and the existing FUNCT3_* and OP_* constants SHALL be reused from it.
REQ-041 Lane extract/extend SHALL be one combinational sub-module, load_align.

Verification
REQ-042 SW addr 0x100, wdata 0xDEADBEEF -> mem_we at T+1, mem_addr 0x100, mask 1111, resp_valid at T+2.
REQ-043 SB addr 0x103, wdata 0x000000A5 -> mask 1000, mem_wdata 0xA5A5A5A5.
REQ-044 LB addr 0x102, mem_rdata 0x12F04455, L=1 -> resp_rdata 0xFFFFFFF0 at T+3; LBU at the same address -> 0x000000F0.
REQ-045 LH addr 0x103 -> with the macro, resp_misaligned=1 at T+1 and no mem_re; without it, addr 0x102 is used.
REQ-046 Load with L=3, rst at T+2 -> IDLE at T+3, no resp_valid, and a new request accepted at T+3.
REQ-047 req_valid held high through a store -> exactly one accept, and req_ready high again at T+3.
